// File: rtl/sid_cmd_bridge.sv
// rtl/sid_cmd_bridge.sv - UART command stream to multi-SID register write bridge
//
// Purpose: parses 2-byte commands from the UART receiver, queues them in a
// FIFO and replays them as SID register writes aligned to the 1 MHz enable.
// Also handles WAIT commands, a parser resync timeout and overflow reporting.
//
// Ports:
//   CLK_IN         system clock (12 MHz)
//   RSTn_i         asynchronous active-low reset
//   rx_data        received UART byte, valid with rx_received
//   rx_received    single-cycle strobe per byte
//   ce_1m          single-cycle SID clock enable
//   clear_overflow synchronous clear of the overflow flag
//   sid_we         per-chip write enable, one-hot while a write is presented
//   sid_addr       SID register address
//   sid_data       SID register data
//   fifo_level     number of queued commands
//   overflow       sticky flag: a command was dropped on a full FIFO
//   busy           queued work, pending wait or write in progress
module sid_cmd_bridge #(
  parameter int NUM_SIDS       = 1,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic                          CLK_IN,
  input  logic                          RSTn_i,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_received,
  input  logic                          ce_1m,
  input  logic                          clear_overflow,
  output logic [NUM_SIDS-1:0]           sid_we,
  output logic [4:0]                    sid_addr,
  output logic [7:0]                    sid_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [2:0] SIDS = 3'(NUM_SIDS);

  typedef enum logic {ST_ADDR, ST_DATA} state_t;

  state_t          state, state_nxt;
  logic [7:0]      byte0, byte0_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic            push_req;
  logic [15:0]     push_entry;

  // FIFO entry layout: {type, cs[1:0], addr[4:0], data[7:0]}
  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic [7:0]      wait_cnt;
  logic            fifo_empty, fifo_full;
  logic            pop, push, ovf_evt;
  logic [15:0]     pop_entry;
  logic [NUM_SIDS-1:0] we_dec;

  // Parser: next-state and push request
  always_comb begin
    state_nxt  = state;
    byte0_nxt  = byte0;
    tcnt_nxt   = tcnt;
    push_req   = 1'b0;
    push_entry = {byte0, rx_data};
    case (state)
      ST_ADDR: begin
        if (rx_received) begin
          byte0_nxt = rx_data;
          tcnt_nxt  = TW'(TIMEOUT_CYCLES - 1);
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        // A byte on the expiry cycle still counts as byte1.
        if (rx_received) begin
          state_nxt = ST_ADDR;
          // Writes to chips that do not exist are consumed silently.
          push_req  = byte0[7] || ({1'b0, byte0[6:5]} < SIDS);
        end else if (tcnt == '0) begin
          state_nxt = ST_ADDR;
        end else begin
          tcnt_nxt = tcnt - TW'(1);
        end
      end
      default: state_nxt = ST_ADDR;
    endcase
  end

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign pop_entry  = mem[rd_ptr];
  assign pop        = ce_1m && (wait_cnt == 8'd0) && !fifo_empty;
  // A pop on the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = push_req && (!fifo_full || pop);
  assign ovf_evt    = push_req && fifo_full && !pop;

  always_comb begin
    we_dec = '0;
    for (int i = 0; i < NUM_SIDS; i++) begin
      we_dec[i] = (pop_entry[14:13] == 2'(i));
    end
  end

  assign busy = !fifo_empty || (wait_cnt != 8'd0) || (|sid_we);
  assign fifo_level = level;

  always_ff @(posedge CLK_IN) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge CLK_IN or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state    <= ST_ADDR;
      byte0    <= 8'd0;
      tcnt     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      wait_cnt <= 8'd0;
      sid_we   <= '0;
      sid_addr <= 5'd0;
      sid_data <= 8'd0;
    end else begin
      state <= state_nxt;
      byte0 <= byte0_nxt;
      tcnt  <= tcnt_nxt;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      // Set wins over a coincident clear.
      if (ovf_evt)             overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;

      if (ce_1m) begin
        if (wait_cnt != 8'd0) begin
          wait_cnt <= wait_cnt - 8'd1;
        end else if (pop && pop_entry[15]) begin
          wait_cnt <= pop_entry[7:0];
        end

        // Each write is held across exactly one ce_1m so the SID samples it
        // once; a back-to-back write replaces it with no idle cycle.
        if (pop && !pop_entry[15]) begin
          sid_we   <= we_dec;
          sid_addr <= pop_entry[12:8];
          sid_data <= pop_entry[7:0];
        end else begin
          sid_we <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sid_cmd_bridge.sv
// tb/tb_sid_cmd_bridge.sv - self-checking bench for sid_cmd_bridge
module tb_sid_cmd_bridge;

  localparam int NS = 2;
  localparam int FD = 4;
  localparam int TO = 40;
  localparam int LW = $clog2(FD) + 1;

  logic           CLK_IN;
  logic           RSTn_i;
  logic [7:0]     rx_data;
  logic           rx_received;
  logic           ce_1m;
  logic           clear_overflow;
  logic [NS-1:0]  sid_we;
  logic [4:0]     sid_addr;
  logic [7:0]     sid_data;
  logic [LW-1:0]  fifo_level;
  logic           overflow;
  logic           busy;

  sid_cmd_bridge #(
    .NUM_SIDS(NS), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_IN(CLK_IN), .RSTn_i(RSTn_i), .rx_data(rx_data),
    .rx_received(rx_received), .ce_1m(ce_1m), .clear_overflow(clear_overflow),
    .sid_we(sid_we), .sid_addr(sid_addr), .sid_data(sid_data),
    .fifo_level(fifo_level), .overflow(overflow), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int tick = 0;
  int base = 0;
  bit ce_en = 0;
  bit m_ovf = 0;
  logic [47:0] cap[$];
  logic [15:0] mq[$];

  initial begin
    CLK_IN = 0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  initial begin
    int cnt;
    cnt = 0;
    ce_1m = 0;
    forever begin
      @(posedge CLK_IN);
      #1;
      if (ce_en) begin
        cnt++;
        if (cnt == 12) begin ce_1m = 1; cnt = 0; end
        else ce_1m = 0;
      end else begin
        ce_1m = 0;
        cnt = 0;
      end
    end
  end

  function automatic logic [47:0] pack(logic [3:0] we, logic [4:0] a, logic [7:0] d, int t);
    logic [23:0] tt;
    tt = t[23:0];
    return {4'b0, we, 3'b0, a, d, tt};
  endfunction

  // Record what each SID samples: the outputs present on every ce_1m.
  initial begin
    forever begin
      @(negedge CLK_IN);
      if (ce_1m) begin
        tick = tick + 1;
        if (sid_we != '0) cap.push_back(pack(4'(sid_we), sid_addr, sid_data, tick));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap = 1);
    repeat (gap) @(posedge CLK_IN);
    #1;
    rx_data = b;
    rx_received = 1;
    @(posedge CLK_IN);
    #1;
    rx_received = 0;
  endtask

  function automatic void model_push(logic [7:0] b0, logic [7:0] b1);
    if (!b0[7] && int'(b0[6:5]) >= NS) return;
    if (mq.size() >= FD) m_ovf = 1;
    else mq.push_back({b0, b1});
  endfunction

  task automatic cmd(input logic [7:0] b0, input logic [7:0] b1);
    send(b0);
    send(b1);
    model_push(b0, b1);
  endtask

  task automatic wait_ce(output bit found);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK_IN);
      if (ce_1m) found = 1;
    end
  endtask

  task automatic drain_start();
    @(posedge CLK_IN);
    #1;
    base = tick;
    ce_en = 1;
  endtask

  // Reference timing: each queued command consumes one ce tick when popped;
  // a WAIT N adds N idle ticks; a write popped on tick t is sampled on t+1.
  task automatic drain_finish(input string tag);
    logic [47:0] exp[$];
    int t;
    for (int i = 0; i < 3000 && busy; i++) @(posedge CLK_IN);
    #1;
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    repeat (3) @(posedge CLK_IN);
    #1;
    ce_en = 0;
    t = base + 1;
    foreach (mq[i]) begin
      if (mq[i][15]) begin
        t += 1 + int'(mq[i][7:0]);
      end else begin
        exp.push_back(pack(4'(1) << mq[i][14:13], mq[i][12:8], mq[i][7:0], t + 1));
        t += 1;
      end
    end
    chk({tag, "_nwr"}, 64'(cap.size()), 64'(exp.size()));
    for (int i = 0; i < cap.size() && i < exp.size(); i++) begin
      chk($sformatf("%s_wr%0d", tag, i), 64'(cap[i]), 64'(exp[i]));
    end
    cap.delete();
    mq.delete();
  endtask

  task automatic pulse_clear();
    @(posedge CLK_IN);
    #1;
    clear_overflow = 1;
    @(posedge CLK_IN);
    #1;
    clear_overflow = 0;
  endtask

  initial begin
    bit found;
    bit busy_low;
    logic [7:0] b0, b1;
    int n;

    RSTn_i = 0;
    rx_data = 0;
    rx_received = 0;
    clear_overflow = 0;
    repeat (3) @(posedge CLK_IN);
    #1;
    RSTn_i = 1;
    @(posedge CLK_IN);
    #1;

    chk("rst_we", 64'(sid_we), 64'(0));
    chk("rst_addr", 64'(sid_addr), 64'(0));
    chk("rst_data", 64'(sid_data), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    // Single write: exact latency and duration
    cmd(8'h18, 8'h0F);
    chk("t1_level", 64'(fifo_level), 64'(1));
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_nowr", 64'(sid_we), 64'(0));
    drain_start();
    wait_ce(found);
    chk("t1_ce0", 64'(found), 64'(1));
    @(posedge CLK_IN);
    #1;
    chk("t1_we", 64'(sid_we), 64'(1));
    chk("t1_addr", 64'(sid_addr), 64'(8'h18));
    chk("t1_data", 64'(sid_data), 64'(8'h0F));
    chk("t1_lvl0", 64'(fifo_level), 64'(0));
    wait_ce(found);
    chk("t1_ce1", 64'(found), 64'(1));
    chk("t1_we_held", 64'(sid_we), 64'(1));
    @(posedge CLK_IN);
    #1;
    chk("t1_we_fall", 64'(sid_we), 64'(0));
    chk("t1_addr_hold", 64'(sid_addr), 64'(8'h18));
    drain_finish("t1");

    // Chip select, back-to-back writes, nonexistent chip dropped silently
    cmd(8'h24, 8'hAA);
    cmd(8'h05, 8'h55);
    cmd(8'h60, 8'h01);
    chk("t2_level", 64'(fifo_level), 64'(2));
    chk("t2_ovf", 64'(overflow), 64'(0));
    drain_start();
    drain_finish("t2");

    // WAIT spacing with busy held high
    cmd(8'h80, 8'h05);
    cmd(8'h01, 8'h33);
    drain_start();
    busy_low = 0;
    for (int i = 0; i < 400 && cap.size() == 0; i++) begin
      @(negedge CLK_IN);
      if (!busy) busy_low = 1;
    end
    chk("t3_busy_held", 64'(busy_low), 64'(0));
    drain_finish("t3");

    // Overflow, set-wins-over-clear, clear, push into full FIFO on a pop
    for (int i = 0; i < 5; i++) cmd(8'(i + 1), 8'(8'hC0 + i));
    chk("t4_level", 64'(fifo_level), 64'(FD));
    chk("t4_ovf", 64'(overflow), 64'(m_ovf));
    send(8'h0A);
    @(posedge CLK_IN);
    #1;
    rx_data = 8'h99;
    rx_received = 1;
    clear_overflow = 1;
    @(posedge CLK_IN);
    #1;
    rx_received = 0;
    clear_overflow = 0;
    model_push(8'h0A, 8'h99);
    chk("t4_setwins", 64'(overflow), 64'(1));
    pulse_clear();
    m_ovf = 0;
    chk("t4_clr", 64'(overflow), 64'(0));
    chk("t4_level2", 64'(fifo_level), 64'(FD));
    send(8'h2B);
    drain_start();
    wait_ce(found);
    chk("t4_ce", 64'(found), 64'(1));
    rx_data = 8'h77;
    rx_received = 1;
    @(posedge CLK_IN);
    #1;
    rx_received = 0;
    mq.push_back({8'h2B, 8'h77});
    chk("t4_pp_level", 64'(fifo_level), 64'(FD));
    chk("t4_pp_ovf", 64'(overflow), 64'(0));
    drain_finish("t4");

    // Parser timeout and the expiry-cycle boundary
    send(8'h10);
    repeat (TO + 5) @(posedge CLK_IN);
    cmd(8'h02, 8'h7F);
    send(8'h01);
    send(8'h33, TO - 1);
    model_push(8'h01, 8'h33);
    send(8'h03);
    send(8'h07, TO);
    send(8'h66);
    model_push(8'h07, 8'h66);
    chk("t5_level", 64'(fifo_level), 64'(3));
    drain_start();
    drain_finish("t5");

    // Randomised command batches
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(2, 7);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          b0 = 8'h80 | 8'($urandom_range(0, 127));
          b1 = 8'($urandom_range(0, 3));
        end else begin
          b0 = {1'b0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
          b1 = 8'($urandom_range(0, 255));
        end
        cmd(b0, b1);
      end
      chk($sformatf("r%0d_level", it), 64'(fifo_level), 64'(mq.size()));
      chk($sformatf("r%0d_ovf", it), 64'(overflow), 64'(m_ovf));
      drain_start();
      drain_finish($sformatf("r%0d", it));
      if (m_ovf) begin
        pulse_clear();
        m_ovf = 0;
        chk($sformatf("r%0d_clr", it), 64'(overflow), 64'(0));
      end
    end

    // Asynchronous reset in the middle of a write
    for (int i = 0; i < 4; i++) cmd(8'(8'h08 + i), 8'(8'h50 + i));
    drain_start();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge CLK_IN);
      #1;
      if (sid_we != '0) found = 1;
    end
    chk("t6_wr_seen", 64'(found), 64'(1));
    chk("t6_level3", 64'(fifo_level), 64'(3));
    #2;
    RSTn_i = 0;
    #1;
    chk("t6_we_async", 64'(sid_we), 64'(0));
    chk("t6_level0", 64'(fifo_level), 64'(0));
    chk("t6_busy0", 64'(busy), 64'(0));
    repeat (2) @(posedge CLK_IN);
    #1;
    RSTn_i = 1;
    cap.delete();
    mq.delete();
    repeat (60) @(posedge CLK_IN);
    #1;
    chk("t6_nowr", 64'(cap.size()), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    ce_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sid_cmd_bridge.md
Name: sid_cmd_bridge

Overview:
- Parametrised successor of the single-SID UART write path.
- Parses a 2-byte command stream from the UART receiver and buffers the commands in a FIFO.
- Replays them as register writes to 1..4 SID instances, aligned to the shared 1 MHz clock enable.
- Adds timed wait commands, a parser resync timeout and overflow reporting; sits between rxuart and the sid8580 instances in the top level.

Parameters:
- NUM_SIDS, 1, number of SID chips addressed (1..4); chip select is byte0[6:5].
- FIFO_DEPTH, 16, command FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 12000, CLK_IN cycles allowed between byte0 and byte1 before the parser resyncs (1 ms at 12 MHz).

Ports:
- CLK_IN  in  1  system clock, 12 MHz.
- RSTn_i  in  1  asynchronous active-low reset.
- rx_data  in  8  received UART byte; valid only while rx_received is high.
- rx_received  in  1  single-cycle strobe, one per byte.
- ce_1m  in  1  single-cycle SID clock enable, one pulse every 12 CLK_IN cycles.
- clear_overflow  in  1  synchronous clear of overflow.
- sid_we  out  NUM_SIDS  per-chip write enable.
- sid_addr  out  5  SID register address.
- sid_data  out  8  SID register data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of entries currently stored.
- overflow  out  1  sticky: a command was dropped because the FIFO was full.
- busy  out  1  high while the FIFO is non-empty OR the wait counter is non-zero OR any sid_we bit is high.

Behaviour:
- Reset (async assert, sync release):
  - Parser returns to ADDR state.
  - FIFO is emptied; wait counter and timeout counter are cleared.
  - sid_we=0, sid_addr=0, sid_data=0, overflow=0, fifo_level=0, busy=0.
- Command format:
  - byte0[7]=0 is a WRITE: cs=byte0[6:5], addr=byte0[4:0], data=byte1.
  - byte0[7]=1 is a WAIT: byte1=N, the number of idle ce_1m ticks; byte0[6:0] are ignored.
- Parser FSM, states ADDR and DATA:
  - ADDR: on rx_received, latch byte0, go to DATA, load the timeout counter with TIMEOUT_CYCLES-1.
  - DATA: on rx_received, form the entry {type, cs, addr, data}, push it to the FIFO, return to ADDR.
  - DATA: the timeout counter decrements each cycle without rx_received; at 0 with no byte, discard byte0 and return to ADDR.
  - A byte arriving on the expiry cycle is accepted as byte1.
- Push rules:
  - WRITE with cs >= NUM_SIDS is consumed but never pushed; no flag is set.
  - Push while the FIFO is full: the entry is dropped, overflow is set, and FIFO contents are unchanged.
  - clear_overflow clears the flag; if it coincides with a new overflow event, set wins.
- Issue engine (acts only on cycles where ce_1m=1):
  - If the wait counter is non-zero, decrement it; no pop.
  - Else if the FIFO is non-empty, pop one entry.
  - Popped WAIT: load the wait counter with N; N=0 gives no delay.
  - Popped WRITE: on the next CLK_IN cycle, drive sid_addr/sid_data and set sid_we[cs]=1, all other bits 0.
- sid_we timing:
  - sid_we stays high until the cycle after the next ce_1m pulse, so each write spans exactly one SID cycle and the SID samples it at that ce_1m.
  - If that same next pulse pops another WRITE, the outputs change directly to the new entry with no gap. Maximum rate is one write per SID cycle.
  - sid_addr/sid_data hold their last value when sid_we=0.
- Simultaneous push and pop on one cycle:
  - fifo_level is unchanged.
  - A push into a full FIFO on a pop cycle succeeds, with no overflow.
  - A pop from an empty FIFO does not occur; the push lands and is popped at the next ce_1m.
- Pointers wrap modulo FIFO_DEPTH; fifo_level is in the range 0..FIFO_DEPTH.
- Reset asserted mid-write drops sid_we to 0 immediately, without waiting for a clock edge.

Test Plan:
- After reset, bytes 0x18, 0x0F (NUM_SIDS=1) -> the first ce_1m after the push pops the entry; next cycle sid_we=1, sid_addr=0x18, sid_data=0x0F; sid_we falls the cycle after the following ce_1m; fifo_level returns to 0.
- NUM_SIDS=2, commands {0x24,0xAA},{0x05,0x55},{0x60,0x01} -> sid_we=2'b10 with addr 0x04/data 0xAA, then 2'b01 with 0x05/0x55 on consecutive SID cycles; third command dropped (cs=3) with no flag.
- WAIT {0x80,0x05} followed by WRITE {0x01,0x33} -> exactly 5 ce_1m pulses with no write between the WAIT pop and the pop of the WRITE; busy stays high throughout.
- FIFO_DEPTH=4, ce_1m held low, 5 write commands -> fifo_level=4, overflow=1, first 4 entries intact; clear_overflow pulse -> overflow=0.
- Byte 0x10, then silence for TIMEOUT_CYCLES+5, then 0x02, 0x7F -> no write of 0x10; write of addr 0x02/data 0x7F occurs.
- RSTn_i pulsed low while sid_we=1 and 3 entries are queued -> sid_we=0 immediately, fifo_level=0, no further writes after release.
